// File: rtl/pixel_pkg.sv
// Shared pixel-format definitions for the YCbCr to RGB444 display path:
// RGB444 layout, BT.601 studio-range coefficients and offsets.
package pixel_pkg;

  localparam int DIFF_W = 9;
  localparam int SUM_W  = 20;

  // Field order puts R in [11:8], G in [7:4], B in [3:0]
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  localparam logic signed [SUM_W-1:0] COEF_Y  = 20'sd298;
  localparam logic signed [SUM_W-1:0] COEF_RV = 20'sd409;
  localparam logic signed [SUM_W-1:0] COEF_GV = 20'sd208;
  localparam logic signed [SUM_W-1:0] COEF_GU = 20'sd100;
  localparam logic signed [SUM_W-1:0] COEF_BU = 20'sd516;

  localparam logic [7:0] Y_OFFSET = 8'd16;
  localparam logic [7:0] C_OFFSET = 8'd128;

  localparam logic signed [SUM_W-1:0] ROUND = 20'sd128;

  function automatic logic signed [SUM_W-1:0] sext_diff(input logic signed [DIFF_W-1:0] v);
    return {{(SUM_W-DIFF_W){v[DIFF_W-1]}}, v};
  endfunction

endpackage

// File: rtl/ycc_clamp4.sv
// One colour channel: fixed-point sum to rounded 8-bit value, clamped to
// 0..255, then reduced to 4 bits as the exact inverse of x17 expansion.
module ycc_clamp4
  import pixel_pkg::*;
(
  input  logic signed [SUM_W-1:0] sum,
  output logic [3:0]              c4,
  output logic                    clipped
);

  logic signed [SUM_W-1:0] rounded;
  logic signed [SUM_W-1:0] c8_wide;
  logic [7:0]              c8;

  always_comb begin
    rounded = sum + ROUND;
    c8_wide = rounded >>> 8;
    clipped = 1'b0;
    c8      = c8_wide[7:0];
    if (c8_wide < 20'sd0) begin
      c8      = 8'd0;
      clipped = 1'b1;
    end else if (c8_wide > 20'sd255) begin
      c8      = 8'd255;
      clipped = 1'b1;
    end
    // (c8*15 + 128) >> 8 maps 17n back to n for every 4-bit n
    c4 = 4'(({4'b0, c8} * 12'd15 + 12'd128) >> 8);
  end

endmodule

// File: rtl/ycbcr_to_rgb444.sv
// Three-stage valid/ready pipeline converting BT.601 studio-range YCbCr to
// RGB444, with a saturating counter of pixels that needed clamping.
module ycbcr_to_rgb444
  import pixel_pkg::*;
#(
  parameter int USER_W     = 1,
  parameter int CLIP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_y,
  input  logic [7:0]            in_cb,
  input  logic [7:0]            in_cr,
  input  logic [USER_W-1:0]     in_user,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [11:0]           out_pixel,
  output logic [USER_W-1:0]     out_user,
  input  logic                  clip_clear,
  output logic [CLIP_CNT_W-1:0] clip_count
);

  logic s1_valid, s2_valid;
  logic s1_adv, s2_adv, s3_adv;

  logic signed [DIFF_W-1:0] s1_yd, s1_cbd, s1_crd;
  logic [USER_W-1:0]        s1_user;

  logic signed [SUM_W-1:0]  s2_r, s2_g, s2_b;
  logic [USER_W-1:0]        s2_user;

  logic [3:0] r4, g4, b4;
  logic       r_clip, g_clip, b_clip;
  logic       any_clip;
  rgb444_t    s3_pixel;

  // Each stage moves when it is empty or its successor moves
  assign s3_adv   = out_ready || !out_valid;
  assign s2_adv   = !s2_valid || s3_adv;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_yd    <= '0;
      s1_cbd   <= '0;
      s1_crd   <= '0;
      s1_user  <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      s1_yd    <= $signed({1'b0, in_y}  - {1'b0, Y_OFFSET});
      s1_cbd   <= $signed({1'b0, in_cb} - {1'b0, C_OFFSET});
      s1_crd   <= $signed({1'b0, in_cr} - {1'b0, C_OFFSET});
      s1_user  <= in_user;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_r     <= '0;
      s2_g     <= '0;
      s2_b     <= '0;
      s2_user  <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      s2_r     <= sext_diff(s1_yd) * COEF_Y + sext_diff(s1_crd) * COEF_RV;
      s2_g     <= sext_diff(s1_yd) * COEF_Y - sext_diff(s1_cbd) * COEF_GU
                - sext_diff(s1_crd) * COEF_GV;
      s2_b     <= sext_diff(s1_yd) * COEF_Y + sext_diff(s1_cbd) * COEF_BU;
      s2_user  <= s1_user;
    end
  end

  ycc_clamp4 u_clamp_r (.sum(s2_r), .c4(r4), .clipped(r_clip));
  ycc_clamp4 u_clamp_g (.sum(s2_g), .c4(g4), .clipped(g_clip));
  ycc_clamp4 u_clamp_b (.sum(s2_b), .c4(b4), .clipped(b_clip));

  assign any_clip = r_clip || g_clip || b_clip;

  always_comb begin
    s3_pixel   = '0;
    s3_pixel.r = r4;
    s3_pixel.g = g4;
    s3_pixel.b = b4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pixel <= 12'h000;
      out_user  <= '0;
    end else if (s3_adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_pixel <= s3_pixel;
        out_user  <= s2_user;
      end
    end
  end

  // Clear beats a simultaneous increment; count sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_count <= '0;
    end else if (clip_clear) begin
      clip_count <= '0;
    end else if (s3_adv && s2_valid && any_clip && (clip_count != '1)) begin
      clip_count <= clip_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_ycbcr_to_rgb444.sv
// Scoreboard bench for ycbcr_to_rgb444: directed colour/latency/clip cases,
// a randomly backpressured stream, and an asynchronous mid-stream reset.
module tb_ycbcr_to_rgb444;

  localparam int USER_W     = 8;
  localparam int CLIP_CNT_W = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [7:0]            in_y, in_cb, in_cr;
  logic [USER_W-1:0]     in_user;
  logic                  out_valid;
  logic                  out_ready;
  logic [11:0]           out_pixel;
  logic [USER_W-1:0]     out_user;
  logic                  clip_clear;
  logic [CLIP_CNT_W-1:0] clip_count;

  ycbcr_to_rgb444 #(.USER_W(USER_W), .CLIP_CNT_W(CLIP_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_y(in_y), .in_cb(in_cb), .in_cr(in_cr), .in_user(in_user),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pixel(out_pixel), .out_user(out_user),
    .clip_clear(clip_clear), .clip_count(clip_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0]       pix;
    logic [USER_W-1:0] user;
  } exp_t;

  exp_t sb[$];
  int   total    = 0;
  int   bad      = 0;
  int   rx_count = 0;
  bit   stream_done;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] model_chan(input int s);
    int   c8;
    logic clip;
    clip = 1'b0;
    c8   = (s + 128) >>> 8;
    if (c8 < 0) begin
      c8   = 0;
      clip = 1'b1;
    end else if (c8 > 255) begin
      c8   = 255;
      clip = 1'b1;
    end
    return {clip, 4'((c8 * 15 + 128) / 256)};
  endfunction

  function automatic logic [12:0] model_pixel(input int y, input int cb, input int cr);
    int yd, cbd, crd;
    logic [4:0] r, g, b;
    yd  = y - 16;
    cbd = cb - 128;
    crd = cr - 128;
    r = model_chan(298 * yd + 409 * crd);
    g = model_chan(298 * yd - 100 * cbd - 208 * crd);
    b = model_chan(298 * yd + 516 * cbd);
    return {r[4] | g[4] | b[4], r[3:0], g[3:0], b[3:0]};
  endfunction

  // Drives one pixel and returns #1 after the edge that accepted it
  task automatic applyStimulus(input logic [7:0] y, input logic [7:0] cb,
                               input logic [7:0] cr, input logic [USER_W-1:0] user);
    logic [12:0] m;
    logic        rdy;
    int          waited;
    in_y     = y;
    in_cb    = cb;
    in_cr    = cr;
    in_user  = user;
    in_valid = 1'b1;
    waited   = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      waited++;
    end while (!rdy && waited < 200);
    if (!rdy) begin
      checkOutput("in_ready_timeout", 32'd0, 32'd1);
    end else begin
      m = model_pixel(int'(y), int'(cb), int'(cr));
      sb.push_back('{pix: m[11:0], user: user});
    end
    #1;
  endtask

  task automatic runDirected(input string tag, input logic [7:0] y, input logic [7:0] cb,
                             input logic [7:0] cr, input logic [USER_W-1:0] user,
                             input logic [11:0] exp_pix, input logic [CLIP_CNT_W-1:0] exp_cnt);
    out_ready = 1'b1;
    applyStimulus(y, cb, cr, user);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    checkOutput({tag, "_lat2"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    checkOutput({tag, "_lat3"}, {31'd0, out_valid}, 32'd1);
    checkOutput({tag, "_pix"}, {20'd0, out_pixel}, {20'd0, exp_pix});
    checkOutput({tag, "_cnt"}, 32'(clip_count), 32'(exp_cnt));
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      rx_count++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("sb_pixel", {20'd0, out_pixel}, {20'd0, e.pix});
        checkOutput("sb_user", 32'(out_user), 32'(e.user));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int rx_start;
    int waited;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_y       = '0;
    in_cb      = '0;
    in_cr      = '0;
    in_user    = '0;
    out_ready  = 1'b1;
    clip_clear = 1'b0;
    stream_done = 1'b0;

    #12;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_pixel", {20'd0, out_pixel}, 32'd0);
    checkOutput("rst_out_user", 32'(out_user), 32'd0);
    checkOutput("rst_clip_count", 32'(clip_count), 32'd0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);

    $display("[TB] directed colours");
    runDirected("black",   8'd16,  8'd128, 8'd128, 8'h01, 12'h000, 2'd0);
    runDirected("white",   8'd235, 8'd128, 8'd128, 8'h02, 12'hFFF, 2'd0);
    runDirected("red",     8'd81,  8'd90,  8'd240, 8'h03, 12'hF00, 2'd1);
    runDirected("overmax", 8'd255, 8'd255, 8'd255, 8'h04, 12'hF7F, 2'd2);

    $display("[TB] buffering and clip saturation");
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) applyStimulus(8'd255, 8'd255, 8'd255, 8'(8'h10 + k));
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("in_ready_full", {31'd0, in_ready}, 32'd0);
    checkOutput("cnt_sat_a", 32'(clip_count), 32'd3);
    repeat (5) @(negedge clk);
    checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("hold_out_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("cnt_sat_b", 32'(clip_count), 32'd3);

    applyStimulus(8'd255, 8'd255, 8'd255, 8'h20);
    in_valid = 1'b0;
    @(posedge clk);
    #1 clip_clear = 1'b1;
    @(posedge clk);
    #1 clip_clear = 1'b0;
    @(negedge clk);
    checkOutput("clear_wins", 32'(clip_count), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] backpressured stream");
    rx_start = rx_count;
    fork
      begin
        for (int i = 0; i < 20; i++)
          applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                        8'($urandom_range(0, 255)), 8'(8'h40 + i));
        in_valid    = 1'b0;
        stream_done = 1'b1;
      end
      begin
        for (int c = 0; c < 2000 && !stream_done; c++) begin
          @(posedge clk);
          #1;
          if (c >= 6 && c < 11) out_ready = 1'b0;
          else                  out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    waited = 0;
    while (sb.size() != 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    #1;
    checkOutput("stream_drain", 32'(sb.size()), 32'd0);
    checkOutput("stream_count", 32'(rx_count - rx_start), 32'd20);

    $display("[TB] mid-stream reset");
    out_ready = 1'b0;
    applyStimulus(8'd255, 8'd255, 8'd255, 8'h60);
    applyStimulus(8'd235, 8'd128, 8'd128, 8'h61);
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    checkOutput("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("async_out_pixel", {20'd0, out_pixel}, 32'd0);
    checkOutput("async_clip_count", 32'(clip_count), 32'd0);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("no_stale", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    runDirected("post_reset", 8'd255, 8'd255, 8'd255, 8'h70, 12'hF7F, 2'd1);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("final_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
